// File: rtl/constant_memory_loader_if.sv
// Handshake and write-port bundle for the constant memory loader.
// slave: loader side (cmd/data in, memory write + status out); master: controller side.
interface constant_memory_loader_if #(
    parameter int ADDR_WIDTH = 9
) ();
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_base_addr_i;
    logic [ADDR_WIDTH:0]   cmd_count_i;
    logic                  data_valid_i;
    logic                  data_ready_o;
    logic [31:0]           data_i;
    logic                  abort_i;
    logic [ADDR_WIDTH-1:0] memory_write_addr_o;
    logic [31:0]           memory_line_o;
    logic                  write_memory_en_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  error_o;

    modport slave (
        input  cmd_valid_i, cmd_base_addr_i, cmd_count_i,
        input  data_valid_i, data_i, abort_i,
        output cmd_ready_o, data_ready_o,
        output memory_write_addr_o, memory_line_o, write_memory_en_o,
        output busy_o, done_o, error_o
    );

    modport master (
        output cmd_valid_i, cmd_base_addr_i, cmd_count_i,
        output data_valid_i, data_i, abort_i,
        input  cmd_ready_o, data_ready_o,
        input  memory_write_addr_o, memory_line_o, write_memory_en_o,
        input  busy_o, done_o, error_o
    );
endinterface

// File: rtl/constant_memory_loader.sv
// Constant memory write feeder: validates base/count commands, streams words
// to consecutive addresses with registered writes. Ports: clk_i, rst_n_i, bus (slave).
module constant_memory_loader #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    constant_memory_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    localparam logic [ADDR_WIDTH+1:0] DEPTH = {2'b01, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH+1:0] sum;
    logic                  cmd_fire;
    logic                  data_fire;
    logic                  cmd_bad;

    assign bus.cmd_ready_o  = (state_q == IDLE);
    assign bus.data_ready_o = (state_q == LOAD) && !bus.abort_i;

    assign cmd_fire  = bus.cmd_valid_i && bus.cmd_ready_o;
    assign data_fire = bus.data_valid_i && bus.data_ready_o;

    // Wide sum so base + count == depth (ends exactly at the top) is legal.
    assign sum     = {2'b00, bus.cmd_base_addr_i} + {1'b0, bus.cmd_count_i};
    assign cmd_bad = (bus.cmd_count_i == '0) || (sum > DEPTH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        line_d  = line_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        ptr_d   = bus.cmd_base_addr_i;
                        cnt_d   = bus.cmd_count_i;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (data_fire) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    line_d = bus.data_i;
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - (ADDR_WIDTH+1)'(1);
                    if (cnt_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flops follow the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.write_memory_en_o   = we_q;
    assign bus.memory_write_addr_o = addr_q;
    assign bus.memory_line_o       = line_q;
    assign bus.busy_o              = busy_q;
    assign bus.done_o              = done_q;
    assign bus.error_o             = err_q;
endmodule

// File: doc/constant_memory_loader.md
# constant_memory_loader

Write-side feeder for the CGRA constant memory. Accepts load commands (base address plus word count) and a 32-bit word stream, both over valid/ready handshakes. Drives the memory's write port with one registered write per accepted word at consecutive addresses. Validates each command against the memory depth and reports completion and rejection to the controller.

## Interface
- ADDR_WIDTH, 9, address width of the constant memory; depth = 2^ADDR_WIDTH words
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  load command present
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i
- cmd_base_addr_i  in  ADDR_WIDTH  first write address
- cmd_count_i  in  ADDR_WIDTH+1  number of words, legal range 1..2^ADDR_WIDTH
- data_valid_i  in  1  data word present
- data_ready_o  out  1  word accepted when high together with data_valid_i
- data_i  in  32  constant word
- abort_i  in  1  cancel current load
- memory_write_addr_o  out  ADDR_WIDTH  write address to the constant memory
- memory_line_o  out  32  write data to the constant memory
- write_memory_en_o  out  1  write strobe to the constant memory
- busy_o  out  1  high in LOAD and DONE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky: last command rejected

## Operation
- Three states: IDLE, LOAD, DONE. Reset enters IDLE.
- cmd_ready_o = (state == IDLE). It is combinational, so it is 1 while reset is held.
- Command handshake in IDLE: compute sum = cmd_base_addr_i + cmd_count_i at ADDR_WIDTH+2 bits.
  - Reject if cmd_count_i == 0 or sum > 2^ADDR_WIDTH. On reject, error_o is set to 1, the state stays IDLE, there are no writes and no done_o.
  - Otherwise, error_o is cleared. The pointer loads base, the remaining counter loads count, and the state goes to LOAD.
- data_ready_o = (state == LOAD) && !abort_i. It is combinational.
- Each data handshake in LOAD: on the next cycle write_memory_en_o = 1, memory_write_addr_o = pointer, memory_line_o = data_i. The pointer then increments by 1 and the remaining counter decrements by 1.
- Addresses never wrap. The validation above guarantees pointer ≤ 2^ADDR_WIDTH − 1 for every write.
- The handshake that brings remaining to 0 moves the state to DONE. DONE lasts exactly one cycle with done_o = 1, then returns to IDLE.
- abort_i in LOAD moves the state to IDLE on the next edge. The cycle's data word is not accepted and not written. No done_o is produced and error_o is unchanged. abort_i in IDLE or DONE is ignored.
- cmd_valid_i outside IDLE is ignored (not accepted). data_valid_i outside LOAD is ignored.

## Timing
- Reset values:
  - state IDLE; cmd_ready_o 1.
  - data_ready_o, write_memory_en_o, done_o, busy_o, error_o all 0.
  - memory_write_addr_o and memory_line_o 0.
  - Pointer and counter 0.
- Write outputs are registered. write_memory_en_o is high for exactly one cycle per accepted word, 1 cycle after its handshake edge. It is 0 in all other cycles.
- The last write and done_o are high in the same cycle. cmd_ready_o returns to 1 the cycle after done_o.
- Back-to-back data (data_valid_i held high) gives one write per cycle with no bubbles.
- Command-to-first-write minimum latency is 2 cycles: command edge, then data handshake edge, then write cycle.
- busy_o is registered from the state and is high for every LOAD and DONE cycle.
- Reset asserted mid-load forces all outputs to their reset values immediately, asynchronously. No further writes occur.

## Test plan (ADDR_WIDTH = 9)
- Reset and idle: hold rst_n_i low, then release -> cmd_ready_o = 1, all other outputs 0, no write strobes for 10 idle cycles.
- Basic load: base = 10, count = 3, data 0xA, 0xB, 0xC back to back -> writes at addresses 10, 11, 12 on three consecutive cycles. done_o is coincident with the write at 12, and a constant-memory readback returns 0xA, 0xB, 0xC.
- Throttled stream: base = 100, count = 4, data_valid_i toggled 1-0-1-1-0-1 -> exactly 4 writes at 100..103, each one cycle after its handshake, with no strobe on idle cycles.
- Depth boundary: three commands in turn.
  - base = 510, count = 2 -> writes at 510 and 511, then done_o.
  - base = 511, count = 2 -> error_o = 1, no writes, cmd_ready_o stays 1.
  - base = 0, count = 512 -> 512 writes at 0..511, and error_o clears on acceptance.
- Zero count: count = 0 -> error_o = 1, state stays IDLE, data_ready_o stays 0.
- Abort and reset: base = 20, count = 5, abort_i asserted after 2 words -> writes at 20 and 21 only, no done_o, cmd_ready_o = 1 next cycle. A repeat with rst_n_i pulsed low after 3 words -> write_memory_en_o = 0 immediately and IDLE after release.
